// File: rtl/random_check.sv
// random_check: receive-side checker for the 16-bit LFSR random stream.
// Self-synchronises to the incoming words, predicts each following word,
// and reports lock status, per-word error pulses and saturating/wrapping counters.
// Optional build macro: RANDOM_CHECK_SEED_EN adds a seed port and starts locked on it.
module random_check #(
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 3
) (
   input  logic        clk,
   input  logic        rst,
`ifdef RANDOM_CHECK_SEED_EN
   input  logic [15:0] seed,
`endif
   input  logic        valid,
   input  logic [15:0] data,
   input  logic        clr,
   output logic        locked,
   output logic        err,
   output logic [15:0] err_cnt,
   output logic [31:0] word_cnt
);

   localparam int unsigned MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
   localparam int unsigned LW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

   typedef enum logic [1:0] {SEEK, VERIFY, LOCKED} state_t;

   state_t          state;
   logic [15:0]     exp_q;
   logic [MW-1:0]   match_q;
   logic [LW-1:0]   miss_q;
   logic            lock_word;
   logic            mismatch;

   // Generator recurrence: feedback from taps 0,2,3,5 shifted in at the top
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   assign lock_word = valid && (state == LOCKED);
   assign mismatch  = (data != exp_q);

   // Synchronisation FSM, predictor and registered lock/error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
`ifdef RANDOM_CHECK_SEED_EN
         state   <= LOCKED;
         exp_q   <= seed;
         locked  <= 1'b1;
`else
         state   <= SEEK;
         exp_q   <= 16'h0000;
         locked  <= 1'b0;
`endif
         match_q <= '0;
         miss_q  <= '0;
         err     <= 1'b0;
      end else begin
         err <= 1'b0;
         if (valid) begin
            case (state)
               SEEK: begin
                  // zero is the LFSR lock-up state and can never seed a stream
                  if (data != 16'h0000) begin
                     exp_q   <= lfsr_next(data);
                     match_q <= '0;
                     state   <= VERIFY;
                  end
               end
               VERIFY: begin
                  if (!mismatch) begin
                     exp_q <= lfsr_next(exp_q);
                     if (match_q == MW'(LOCK_CNT - 1)) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                        miss_q <= '0;
                     end else begin
                        match_q <= match_q + MW'(1);
                     end
                  end else if (data != 16'h0000) begin
                     exp_q   <= lfsr_next(data);
                     match_q <= '0;
                  end else begin
                     state <= SEEK;
                  end
               end
               LOCKED: begin
                  // flywheel: predictor advances from its own state, never from data
                  exp_q <= lfsr_next(exp_q);
                  if (!mismatch) begin
                     miss_q <= '0;
                  end else begin
                     err <= 1'b1;
                     if (miss_q == LW'(LOSS_CNT - 1)) begin
                        state  <= SEEK;
                        locked <= 1'b0;
                     end else begin
                        miss_q <= miss_q + LW'(1);
                     end
                  end
               end
               default: begin
                  state  <= SEEK;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

   // Error and word counters; clr wins over a coincident count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt  <= 16'h0000;
         word_cnt <= 32'h0000_0000;
      end else if (clr) begin
         err_cnt  <= 16'h0000;
         word_cnt <= 32'h0000_0000;
      end else if (lock_word) begin
         word_cnt <= word_cnt + 32'd1;
         if (mismatch && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_random_check.sv
// tb_random_check: table-driven scoreboard bench for random_check (LOCK_CNT=4, LOSS_CNT=3).
module tb_random_check;

   typedef struct packed {
      logic        v;
      logic [15:0] d;
      logic        c;
      logic        lk;
      logic        er;
      logic [15:0] ec;
      logic [31:0] wc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [15:0] data;
   logic        clr;
   logic        locked;
   logic        err;
   logic [15:0] err_cnt;
   logic [31:0] word_cnt;
`ifdef RANDOM_CHECK_SEED_EN
   logic [15:0] seed;
`endif

   int          checks   = 0;
   int          failures = 0;
   vec_t        vecs[$];
   vec_t        sb[$];
   logic [15:0] g;
   logic [15:0] w;

   always #5 clk = ~clk;

   random_check #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef RANDOM_CHECK_SEED_EN
      .seed     (seed),
`endif
      .valid    (valid),
      .data     (data),
      .clr      (clr),
      .locked   (locked),
      .err      (err),
      .err_cnt  (err_cnt),
      .word_cnt (word_cnt)
   );

   // Reference generator: feedback is the parity of taps 0x002D
   function automatic logic [15:0] tb_next(input logic [15:0] s);
      logic fb;
      fb = ^(s & 16'h002D);
      return (s >> 1) | ({15'h0, fb} << 15);
   endfunction

   task automatic nw(output logic [15:0] o);
      o = g;
      g = tb_next(g);
   endtask

   task automatic add(input logic v, input logic [15:0] d, input logic c,
                      input logic lk, input logic er, input logic [15:0] ec,
                      input logic [31:0] wc);
      vec_t r;
      r = '{v: v, d: d, c: c, lk: lk, er: er, ec: ec, wc: wc};
      vecs.push_back(r);
   endtask

   task automatic chk(input string nm, input int row, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s row=%0d actual=%h required=%h", nm, row, act, req);
      end
   endtask

   // Drive each vector, queue its expectation, compare after the sampling edge
   task automatic run_table;
      vec_t e;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         valid = vecs[i].v;
         data  = vecs[i].d;
         clr   = vecs[i].c;
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk("locked",   i, 32'(locked),  32'(e.lk));
         chk("err",      i, 32'(err),     32'(e.er));
         chk("err_cnt",  i, 32'(err_cnt), 32'(e.ec));
         chk("word_cnt", i, word_cnt,     e.wc);
      end
      @(negedge clk);
      valid = 1'b0;
      clr   = 1'b0;
      vecs.delete();
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst   = 1'b1;
      valid = 1'b0;
      clr   = 1'b0;
      #1;
`ifdef RANDOM_CHECK_SEED_EN
      chk("rst_locked", -1, 32'(locked), 32'd1);
`else
      chk("rst_locked", -1, 32'(locked), 32'd0);
`endif
      chk("rst_err",      -1, 32'(err),     32'd0);
      chk("rst_err_cnt",  -1, 32'(err_cnt), 32'd0);
      chk("rst_word_cnt", -1, word_cnt,     32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      clr   = 1'b0;
      data  = 16'h0000;
`ifdef RANDOM_CHECK_SEED_EN
      seed  = 16'hACE1;
`endif
      repeat (2) @(posedge clk);
      do_reset();

`ifdef RANDOM_CHECK_SEED_EN
      // Starts locked on seed: correct first word, then a wrong first word
      add(1, 16'hACE1, 0, 1, 0, 0, 1);
      add(1, 16'h5670, 0, 1, 0, 0, 2);
      run_table();
      do_reset();
      add(1, 16'h1234, 0, 1, 1, 1, 1);
      add(1, 16'h5670, 0, 1, 0, 1, 2);
      run_table();
`else
      // Clean stream: lock at the 5th word, counting from the 6th
      g = 16'hACE1;
      for (int i = 0; i < 4; i++) begin nw(w); add(1, w, 0, 0, 0, 0, 0); end
      nw(w); add(1, w, 0, 1, 0, 0, 0);
      nw(w); add(1, w, 0, 1, 0, 0, 1);
      nw(w); add(1, w, 0, 1, 0, 0, 2);
      // Single flipped bit, then a correct word (flywheel)
      nw(w); add(1, w ^ 16'h0008, 0, 1, 1, 1, 3);
      nw(w); add(1, w, 0, 1, 0, 1, 4);
      // Idle clear
      add(0, 16'hFFFF, 1, 1, 0, 0, 0);
      // Three consecutive bad words lose lock on the third
      nw(w); add(1, w ^ 16'h0008, 0, 1, 1, 1, 1);
      nw(w); add(1, w ^ 16'h0008, 0, 1, 1, 2, 2);
      nw(w); add(1, w ^ 16'h0008, 0, 0, 1, 3, 3);
      // Five clean words relock
      for (int i = 0; i < 4; i++) begin nw(w); add(1, w, 0, 0, 0, 3, 3); end
      nw(w); add(1, w, 0, 1, 0, 3, 3);
      // Reach err_cnt=5, then clr on a mismatch
      nw(w); add(1, w ^ 16'h0100, 0, 1, 1, 4, 4);
      nw(w); add(1, w ^ 16'h0100, 0, 1, 1, 5, 5);
      nw(w); add(1, w, 0, 1, 0, 5, 6);
      nw(w); add(1, w ^ 16'h0008, 1, 1, 1, 0, 0);
      nw(w); add(1, w, 0, 1, 0, 0, 1);
      run_table();

      // Mid-stream reset returns to reset state immediately
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_locked",   -2, 32'(locked),  32'd0);
      chk("midrst_word_cnt", -2, word_cnt,     32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Zeros ignored in SEEK, gap in VERIFY holds state
      g = 16'h1D2C;
      for (int i = 0; i < 3; i++) add(1, 16'h0000, 0, 0, 0, 0, 0);
      nw(w); add(1, w, 0, 0, 0, 0, 0);
      nw(w); add(1, w, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++)
         add(0, (i % 2 == 0) ? 16'h0000 : 16'hBEEF, 0, 0, 0, 0, 0);
      nw(w); add(1, w, 0, 0, 0, 0, 0);
      nw(w); add(1, w, 0, 0, 0, 0, 0);
      nw(w); add(1, w, 0, 1, 0, 0, 0);
      nw(w); add(1, w, 0, 1, 0, 0, 1);
      // Zero in VERIFY drops to SEEK: relock needs a fresh seed plus four matches
      g = 16'hACE1;
      add(1, 16'h0000, 0, 1, 1, 1, 2);
      add(1, 16'h0000, 0, 1, 1, 2, 3);
      add(1, 16'h0000, 0, 0, 1, 3, 4);
      nw(w); add(1, w, 0, 0, 0, 3, 4);
      nw(w); add(1, w, 0, 0, 0, 3, 4);
      add(1, 16'h0000, 0, 0, 0, 3, 4);
      nw(w); add(1, w, 0, 0, 0, 3, 4);
      for (int i = 0; i < 3; i++) begin nw(w); add(1, w, 0, 0, 0, 3, 4); end
      nw(w); add(1, w, 0, 1, 0, 3, 4);
      run_table();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/random_check.md
# random_check

Stream checker for the 16-bit LFSR random generator in this design; it sits on the receive side of a random-data link. It self-synchronises to the incoming word stream, predicts each following word with the same recurrence, and counts mismatches. It reports lock status, a per-word error pulse, a saturating error count and a received-word count.

## Interface
- LOCK_CNT, 4: consecutive matching words after the first seed word needed to declare lock (≥1)
- LOSS_CNT, 3: consecutive mismatches while locked that force loss of lock (≥1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- valid  in  1  data is a word to check this cycle
- data  in  16  received word
- clr  in  1  synchronous clear of err_cnt and word_cnt
- locked  out  1  checker is in LOCKED
- err  out  1  one-cycle pulse: a locked word mismatched
- err_cnt  out  16  mismatch count, saturates at 0xFFFF
- word_cnt  out  32  words checked while locked, wraps

One clock; reset is asynchronous and active-high.

## Operation
- Recurrence: next(s) = {s[0]^s[2]^s[3]^s[5], s[15:1]}; for example, next(0xACE1) = 0x5670. The word stream is seed, next(seed), next²(seed), and so on.
- Internal registers: exp[15:0] (predicted word), match count, miss count, and the FSM {SEEK, VERIFY, LOCKED}.
- When valid=0, every register holds its value.
- SEEK:
  - valid with data≠0: exp ← next(data), match count ← 0, go to VERIFY.
  - data=0: ignored, because 0 is the LFSR lock-up state.
- VERIFY:
  - valid with data==exp: exp ← next(exp) and the match count increments. When the count reaches LOCK_CNT−1 on this word, go to LOCKED with miss count ← 0.
  - valid with data≠exp and data≠0: reseed with exp ← next(data) and match count ← 0; stay in VERIFY.
  - valid with data=0: go to SEEK.
  - No error is counted in VERIFY.
- LOCKED:
  - On every valid word: word_cnt increments and exp ← next(exp). The predictor always advances from exp, never from data.
  - Match: miss count ← 0.
  - Mismatch: err pulses, err_cnt increments (holds at 0xFFFF) and the miss count increments. When the count reaches LOSS_CNT−1 on this mismatch, go to SEEK.
- clr:
  - Zeroes err_cnt and word_cnt.
  - If clr coincides with a counting event, clr wins and the counter ends at 0; err still pulses.
  - clr does not affect the FSM or exp.
- Reset values: SEEK, exp=0, locked=0, err=0, err_cnt=0, word_cnt=0. When RANDOM_CHECK_SEED_EN is defined, see Configuration.

## Timing
- All outputs are registered. Results for a word sampled at edge N appear after edge N.
  - err is high for exactly the one cycle after edge N.
  - Counters update at edge N.
  - locked changes at edge N.
- Lock latency from a clean stream: 1 + LOCK_CNT valid words. locked rises at the edge that samples word 1+LOCK_CNT.
- Loss latency: locked falls at the edge that samples the LOSS_CNT-th consecutive bad word.
- Back-to-back valid words are accepted every cycle. There is no backpressure.
- Asserting rst mid-stream returns the checker to its reset state immediately. Counters are not preserved.

## Configuration
- RANDOM_CHECK_SEED_EN defined:
  - Adds the port seed (in, 16), the generator's seed value.
  - At reset the FSM enters LOCKED with exp=seed and locked=1, so the first word after reset is checked against seed.
  - Loss and re-acquisition then work as described in Operation.
- RANDOM_CHECK_SEED_EN undefined: the seed port is absent and the checker always starts in SEEK.

## Test plan
- Clean stream, LOCK_CNT=4: 0xACE1, 0x5670, … on consecutive cycles → locked rises at the 5th word, err never pulses, err_cnt=0, and word_cnt counts from the 6th word.
- Locked, one word with bit 3 flipped → err high for one cycle, err_cnt=1, locked stays 1, and the next correct word produces no err (flywheel).
- Locked, 3 consecutive corrupt words (LOSS_CNT=3) → err_cnt=3 and locked falls on the 3rd. Five further clean words then relock.
- Stream of 0x0000 words in SEEK, then valid low for 10 cycles inside VERIFY → FSM stays in SEEK during the zeros, and all state holds during the gap.
- clr asserted on the same cycle as a locked mismatch with err_cnt=5 → err pulses and err_cnt=0.
- RANDOM_CHECK_SEED_EN defined, seed=0xACE1: first word 0xACE1 → no err. Separately, first word 0x1234 → err pulses and err_cnt=1.
